// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter
//   Shares the single VGA adapter pixel-write port among several drawing
//   engines (splash screen, tower sprites, enemies, HUD). Grants are
//   round-robin and locked for a whole burst, so one sprite's pixels are
//   never interleaved with another's.
//
// Optional build macro: DRAW_TIMEOUT_EN
//   When defined, a watchdog revokes a grant held for MAX_BURST cycles.
//   The revocation is flagged by a one-cycle pulse on timeout.
//   Without the macro, timeout stays 0 and bursts are unbounded.
//
// Ports:
//   clk         system clock
//   resetn      asynchronous active-low reset
//   req         per-requester burst request, held for the whole burst
//   req_plot    per-requester pixel-write strobe
//   req_last    last pixel of a burst, qualified by req_plot
//   req_x/y/colour  packed per-requester pixel data, requester i at [i*W +: W]
//   gnt         registered one-hot grant
//   vga_x/y/colour/plot  registered pixel write to the adapter
//   busy        high while a grant is active
//   timeout     watchdog revocation pulse (0 unless DRAW_TIMEOUT_EN)
module vga_draw_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int COL_W     = 3,
  parameter int MAX_BURST = 19200
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_plot,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*X_W-1:0]   req_x,
  input  logic [NUM_REQ*Y_W-1:0]   req_y,
  input  logic [NUM_REQ*COL_W-1:0] req_colour,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [COL_W-1:0]         vga_colour,
  output logic                     vga_plot,
  output logic                     busy,
  output logic                     timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] WD_LIMIT = 16'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t state, state_nxt;

  logic [NUM_REQ-1:0] gnt_nxt;
  logic [IDX_W-1:0]   gnt_idx, gnt_idx_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]   ptr_after_gnt;
  logic [X_W-1:0]     vga_x_nxt;
  logic [Y_W-1:0]     vga_y_nxt;
  logic [COL_W-1:0]   vga_colour_nxt;
  logic               vga_plot_nxt;
  logic               timeout_nxt;
  logic [15:0]        burst_cnt, burst_cnt_nxt;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  int unsigned        cand;

  logic               g_req, g_plot, g_last;
  logic               wd_hit;

`ifdef DRAW_TIMEOUT_EN
  assign wd_hit = (burst_cnt == WD_LIMIT);
`else
  assign wd_hit = 1'b0;
`endif

  // First requester at or after rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - 32'(NUM_REQ);
      if (!pick_valid && req[cand[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign g_req  = req[gnt_idx];
  assign g_plot = req_plot[gnt_idx];
  assign g_last = req_last[gnt_idx];

  assign ptr_after_gnt = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    gnt_idx_nxt    = gnt_idx;
    rr_ptr_nxt     = rr_ptr;
    vga_x_nxt      = vga_x;
    vga_y_nxt      = vga_y;
    vga_colour_nxt = vga_colour;
    vga_plot_nxt   = 1'b0;
    timeout_nxt    = 1'b0;
    burst_cnt_nxt  = burst_cnt;

    case (state)
      S_IDLE: begin
        if (pick_valid) begin
          gnt_nxt           = '0;
          gnt_nxt[pick_idx] = 1'b1;
          gnt_idx_nxt       = pick_idx;
          burst_cnt_nxt     = '0;
          state_nxt         = S_GRANT;
        end
      end

      S_GRANT: begin
        // Saturating at the watchdog limit keeps the counter meaningful
        // in both builds; the burst ends there anyway when the watchdog is on.
        if (burst_cnt != WD_LIMIT) burst_cnt_nxt = burst_cnt + 16'd1;

        if (!g_req) begin
          // Abort: the requester has walked away, drop this cycle's pixel.
          gnt_nxt    = '0;
          rr_ptr_nxt = ptr_after_gnt;
          state_nxt  = S_RELEASE;
        end else begin
          vga_plot_nxt = g_plot;
          if (g_plot) begin
            vga_x_nxt      = req_x[gnt_idx*X_W +: X_W];
            vga_y_nxt      = req_y[gnt_idx*Y_W +: Y_W];
            vga_colour_nxt = req_colour[gnt_idx*COL_W +: COL_W];
          end
          if ((g_plot && g_last) || wd_hit) begin
            gnt_nxt     = '0;
            rr_ptr_nxt  = ptr_after_gnt;
            state_nxt   = S_RELEASE;
            timeout_nxt = wd_hit && !(g_plot && g_last);
          end
        end
      end

      S_RELEASE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      gnt        <= '0;
      gnt_idx    <= '0;
      rr_ptr     <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      timeout    <= 1'b0;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      gnt_idx    <= gnt_idx_nxt;
      rr_ptr     <= rr_ptr_nxt;
      vga_x      <= vga_x_nxt;
      vga_y      <= vga_y_nxt;
      vga_colour <= vga_colour_nxt;
      vga_plot   <= vga_plot_nxt;
      timeout    <= timeout_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  assign busy = (state == S_GRANT);

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Testbench for vga_draw_arbiter (default build, watchdog disabled).
module tb_vga_draw_arbiter;

  localparam int NUM_REQ = 4;
  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int COL_W   = 3;
  localparam int PIX_W   = X_W + Y_W + COL_W;

  logic                     clk = 1'b0;
  logic                     resetn;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       req_plot;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ*X_W-1:0]   req_x;
  logic [NUM_REQ*Y_W-1:0]   req_y;
  logic [NUM_REQ*COL_W-1:0] req_colour;
  logic [NUM_REQ-1:0]       gnt;
  logic [X_W-1:0]           vga_x;
  logic [Y_W-1:0]           vga_y;
  logic [COL_W-1:0]         vga_colour;
  logic                     vga_plot;
  logic                     busy;
  logic                     timeout;

  vga_draw_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .X_W      (X_W),
    .Y_W      (Y_W),
    .COL_W    (COL_W),
    .MAX_BURST(19200)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .req_plot  (req_plot),
    .req_last  (req_last),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_colour(req_colour),
    .gnt       (gnt),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_checks   = 0;
  int n_errors   = 0;
  int plot_count = 0;
  logic [PIX_W-1:0] sb_q[$];
  logic [PIX_W-1:0] exp_pix;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every forwarded pixel must match the head of the scoreboard.
  always @(negedge clk) begin
    if (resetn) begin
      check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
      check("timeout_low", 32'(timeout), 32'd0);
      if (vga_plot) begin
        plot_count++;
        check("plot_expected", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          exp_pix = sb_q.pop_front();
          check("vga_x",      32'(vga_x),      32'(exp_pix[PIX_W-1 -: X_W]));
          check("vga_y",      32'(vga_y),      32'(exp_pix[COL_W +: Y_W]));
          check("vga_colour", 32'(vga_colour), 32'(exp_pix[COL_W-1:0]));
        end
      end
    end
  end

  task automatic wait_grant(output int idx, input int budget);
    idx = -1;
    for (int c = 0; c < budget && gnt == '0; c++) tick();
    check("grant_seen", 32'(gnt != '0), 32'd1);
    for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) idx = i;
  endtask

  task automatic pixel(input int idx, input int x, input int y, input int c,
                       input bit last, input bit fwd);
    req_x[idx*X_W +: X_W]           = X_W'(x);
    req_y[idx*Y_W +: Y_W]           = Y_W'(y);
    req_colour[idx*COL_W +: COL_W]  = COL_W'(c);
    req_plot[idx] = 1'b1;
    req_last[idx] = last;
    if (fwd) sb_q.push_back({X_W'(x), Y_W'(y), COL_W'(c)});
    tick();
    req_plot[idx] = 1'b0;
    req_last[idx] = 1'b0;
  endtask

  int idx;
  int p0;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; req = '0; req_plot = '0; req_last = '0;
    req_x = '0; req_y = '0; req_colour = '0;
    tick(); tick();
    check("rst_gnt",     32'(gnt),        32'd0);
    check("rst_plot",    32'(vga_plot),   32'd0);
    check("rst_busy",    32'(busy),       32'd0);
    check("rst_x",       32'(vga_x),      32'd0);
    check("rst_y",       32'(vga_y),      32'd0);
    check("rst_colour",  32'(vga_colour), 32'd0);
    check("rst_timeout", 32'(timeout),    32'd0);
    resetn = 1'b1;
    tick();

    // Single 3-pixel burst from requester 0.
    req = 4'b0001;
    check("t1_gnt_before", 32'(gnt), 32'd0);
    tick();
    check("t1_gnt_latency", 32'(gnt), 32'b0001);
    check("t1_busy", 32'(busy), 32'd1);
    p0 = plot_count;
    pixel(0, 5, 10, 4, 1'b0, 1'b1);
    pixel(0, 6, 10, 4, 1'b0, 1'b1);
    pixel(0, 7, 10, 4, 1'b1, 1'b1);
    check("t1_gnt_release", 32'(gnt), 32'd0);
    check("t1_busy_release", 32'(busy), 32'd0);
    req = '0;
    tick();
    check("t1_hold_x", 32'(vga_x), 32'd7);
    tick();
    check("t1_plot_count", 32'(plot_count - p0), 32'd3);
    check("t1_sb_empty", 32'(sb_q.size()), 32'd0);
    // rr_ptr moved to 1: with 0 and 1 both requesting, 1 wins.
    req = 4'b0011;
    wait_grant(idx, 8);
    check("t1_rr_ptr", 32'(idx), 32'd1);
    pixel(1, 8, 11, 1, 1'b1, 1'b1);
    req = '0;
    tick(); tick();

    // Round-robin over all four requesters from a fresh pointer.
    resetn = 1'b0; tick(); resetn = 1'b1; tick();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(idx, 8);
      check("t2_order", 32'(idx), 32'(exp_order[k]));
      pixel(idx, 20 + k, 30, k, 1'b1, 1'b1);
      check("t2_gap", 32'(gnt), 32'd0);
    end
    req = '0;
    tick(); tick();
    check("t2_sb_empty", 32'(sb_q.size()), 32'd0);

    // Requester 2 granted; requester 1 plotting without a grant is ignored.
    req = 4'b0100;
    wait_grant(idx, 8);
    check("t3_idx", 32'(idx), 32'd2);
    p0 = plot_count;
    req_x[1*X_W +: X_W] = 8'd99;
    req_plot[1] = 1'b1;
    pixel(2, 40, 50, 2, 1'b0, 1'b1);
    tick();
    req_plot[1] = 1'b0;
    pixel(2, 41, 50, 2, 1'b1, 1'b1);
    check("t3_gnt_release", 32'(gnt), 32'd0);
    req = '0;
    tick(); tick();
    check("t3_plot_count", 32'(plot_count - p0), 32'd2);
    check("t3_hold_x", 32'(vga_x), 32'd41);
    check("t3_sb_empty", 32'(sb_q.size()), 32'd0);

    // Requester 3 aborts after 5 pixels; the abort-cycle pixel is dropped.
    req = 4'b1000;
    wait_grant(idx, 8);
    check("t4_idx", 32'(idx), 32'd3);
    p0 = plot_count;
    for (int k = 0; k < 5; k++) pixel(3, 60 + k, 70, 5, 1'b0, 1'b1);
    req[3] = 1'b0;
    pixel(3, 77, 70, 5, 1'b0, 1'b0);
    check("t4_abort_gnt", 32'(gnt), 32'd0);
    tick(); tick();
    check("t4_plot_count", 32'(plot_count - p0), 32'd5);
    check("t4_hold_x", 32'(vga_x), 32'd64);
    check("t4_sb_empty", 32'(sb_q.size()), 32'd0);
    req = 4'b0011;
    wait_grant(idx, 8);
    check("t4_rr_wrap", 32'(idx), 32'd0);
    pixel(0, 9, 9, 1, 1'b1, 1'b1);
    req = '0;
    tick(); tick();

    // Asynchronous reset in the middle of requester 1's burst.
    req = 4'b0010;
    wait_grant(idx, 8);
    check("t5_idx", 32'(idx), 32'd1);
    pixel(1, 90, 91, 3, 1'b0, 1'b1);
    pixel(1, 92, 91, 3, 1'b0, 1'b1);
    req_x[1*X_W +: X_W] = 8'd93;
    req_plot[1] = 1'b1;
    #5;
    resetn = 1'b0;
    #1;
    check("t5_rst_gnt",  32'(gnt),      32'd0);
    check("t5_rst_plot", 32'(vga_plot), 32'd0);
    check("t5_rst_busy", 32'(busy),     32'd0);
    req = '0; req_plot = '0;
    tick();
    resetn = 1'b1;
    tick();
    check("t5_idle_gnt", 32'(gnt), 32'd0);
    check("t5_sb_empty", 32'(sb_q.size()), 32'd0);
    req = 4'b0011;
    wait_grant(idx, 8);
    check("t5_rr_reset", 32'(idx), 32'd0);
    pixel(0, 12, 13, 6, 1'b1, 1'b1);
    req = '0;
    tick(); tick();
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_draw_arbiter.md
Name: vga_draw_arbiter

Overview:
- Shares the single VGA adapter pixel-write port (x, y, colour, plot) among several drawing engines: stage splash screen, tower sprite drawer, enemy drawer and HUD drawer.
- Round-robin arbitration with burst locking. A requester keeps the port for a whole sprite/screen burst, so one sprite's pixels are never interleaved with another's.
- Sits between the game-flow-driven draw engines and the VGA adapter instance in the top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- X_W, 8, x coordinate width (160-column adapter).
- Y_W, 7, y coordinate width (120-row adapter).
- COL_W, 3, colour width.
- MAX_BURST, 19200, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester burst request, held high for the whole burst
- req_plot  in  NUM_REQ  per-requester pixel-write strobe
- req_last  in  NUM_REQ  marks the final pixel of a burst; valid only together with req_plot
- req_x  in  NUM_REQ*X_W  packed x coordinates, requester i at [i*X_W +: X_W]
- req_y  in  NUM_REQ*Y_W  packed y coordinates
- req_colour  in  NUM_REQ*COL_W  packed colours
- gnt  out  NUM_REQ  one-hot grant, registered
- vga_x  out  X_W  to adapter
- vga_y  out  Y_W  to adapter
- vga_colour  out  COL_W  to adapter
- vga_plot  out  1  to adapter write enable
- busy  out  1  high while any grant is active
- timeout  out  1  one-cycle pulse when the watchdog revokes a grant (optional feature only)

Behaviour:
- Reset (async, resetn low):
  - state=IDLE, gnt=0, rr_ptr=0, vga_x/y/colour=0, vga_plot=0, busy=0, timeout=0, burst counter=0.
  - Reset mid-burst drops the grant and plot immediately; no partial pixel is emitted after resetn falls.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If any req bit is high, pick the first set bit at or after rr_ptr, searching upward and wrapping at NUM_REQ-1 -> 0.
  - Set gnt one-hot and go to GRANT. Grant appears the cycle after req is sampled.
- GRANT:
  - Each cycle, register the granted requester's x/y/colour/plot onto the vga_* outputs. This is a 1-cycle latency from req_plot to vga_plot.
  - Plot strobes from non-granted requesters are ignored and lost. Requesters must not plot before seeing gnt.
  - Burst ends when the granted requester asserts req_plot&req_last, which is the last pixel and is still forwarded. It also ends on a burst abort: the granted req drops.
  - On burst end: gnt=0, rr_ptr = granted index + 1, wrapping to 0 past NUM_REQ-1. Go to RELEASE.
  - During the cycle that the abort is detected, that cycle's plot is not forwarded.
- RELEASE:
  - One idle cycle; vga_plot=0, gnt=0. Gives the released engine time to drop req.
  - Then go to IDLE. The earliest re-grant is 2 cycles after burst end.
- busy = (state==GRANT).
- When vga_plot=0, vga_x/y/colour hold their last values.
- Simultaneous requests: rr_ptr decides. A requester that just finished has the lowest priority next round.
- A single continuous requester is re-granted every 3 cycles of overhead (GRANT end, RELEASE, IDLE).
- Burst counter (16 bits) counts GRANT cycles and clears on entering GRANT. Without the optional feature it is unused, and synthesis may prune it.

Optional Feature:
- Macro DRAW_TIMEOUT_EN.
- Defined: if the burst counter reaches MAX_BURST-1 while in GRANT, the arbiter forcibly ends the burst.
  - gnt drops, rr_ptr advances, state goes to RELEASE, timeout pulses high for exactly 1 cycle.
  - A hung draw engine therefore cannot freeze the display.
- Undefined: no watchdog, timeout is tied to 0, and a burst lasts until last/abort regardless of length.

Test Plan:
- Reset, then req=4'b0001 and drive 3 pixels (x=5,6,7; y=10; colour=3'b100) with last on the 3rd -> gnt=0001 one cycle after req; vga_plot high for 3 cycles, 1 cycle after each req_plot, carrying x=5,6,7; gnt=0 after the 3rd pixel; rr_ptr=1.
- req=4'b1111 held, each requester doing a 1-pixel burst with last -> grants in order 0,1,2,3,0; exactly one gnt bit high at any time; RELEASE gap of ≥1 cycle between grants.
- Requester 2 granted, requester 1 pulses req_plot with x=99 -> vga_x never shows 99; no vga_plot from requester 1.
- Requester 3 granted, drops req mid-burst after 5 pixels -> exactly 5 vga_plot pulses; gnt clears; rr_ptr wraps to 0.
- resetn pulsed low mid-burst of requester 1 -> gnt=0 and vga_plot=0 asynchronously; after release, IDLE and rr_ptr=0.
- With DRAW_TIMEOUT_EN and MAX_BURST=16, requester 0 holds req with no last -> gnt drops after 16 GRANT cycles; timeout is a single 1-cycle pulse; requester 1, if requesting, is granted next.
